fetch_queue: RTL

Instruction prefetch queue between instruction memory and the decode stage: owns the fetch PC, issues in-order requests to a variable-latency instruction memory, buffers returned instructions with their PCs, and presents them to decode with a valid/stall handshake. It replaces the fixed-latency fetch path. On a taken branch or jump from execute it redirects the PC, discards in-flight responses, and flushes buffered entries.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_queue.sv | 111 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Imported by fetch_fifo and fetch_queue.
package fetch_pkg;

   localparam int FQ_DEPTH = 4;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Register-based FIFO of fetched instructions with their PCs.
// Clear wins over push/pop so a redirect empties it in one edge.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  fq_entry_t     push_data,
   input  logic          pop,
   input  logic          clear,
   output fq_entry_t     head,
   output logic [CW-1:0] count
);

   fq_entry_t     mem_q [DEPTH];
   fq_entry_t     mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   always_comb begin
      do_push  = push && !clear;
      do_pop   = pop && !clear && (count_q != '0);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Prefetch queue: owns the fetch PC, issues credit-limited requests to a
// variable-latency instruction memory and buffers responses for decode.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = FQ_DEPTH,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic        ImemGnt,
   input  logic        ImemRspValid,
   input  logic [31:0] ImemRspData,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   input  logic        StallD,
   output logic        ValidD,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [CW-1:0] count;
   logic [CW:0]   occupancy;
   logic          gnt, rsp_ok, push, pop;
   fq_entry_t     head, push_data;

   // Every in-flight request reserves a slot, so a push never meets a full queue.
   assign occupancy = {1'b0, count} + {1'b0, inflight_q};
   assign ImemReq   = reset && !PCSrcE && (occupancy < CAP);
   assign ImemAddr  = fetch_pc_q;
   assign gnt       = ImemReq && ImemGnt;
   assign rsp_ok    = ImemRspValid && (inflight_q != '0);
   assign pop       = ValidD && !StallD && !PCSrcE;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      discard_d  = discard_q;
      push       = 1'b0;
      inflight_d = inflight_q + CW'(gnt) - CW'(rsp_ok);
      if (gnt) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (PCSrcE) begin
         fetch_pc_d = PCTargetE;
         rsp_pc_d   = PCTargetE;
         discard_d  = inflight_q - CW'(rsp_ok);
      end else if (rsp_ok) begin
         if (discard_q != '0) begin
            discard_d = discard_q - CW'(1);
         end else begin
            push     = 1'b1;
            rsp_pc_d = rsp_pc_q + 32'd4;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

   always_comb begin
      push_data       = '0;
      push_data.instr = ImemRspData;
      push_data.pc    = rsp_pc_q;
   end

   fetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_data(push_data),
      .pop      (pop),
      .clear    (PCSrcE),
      .head     (head),
      .count    (count)
   );

   assign ValidD   = (count != '0);
   assign InstrD   = ValidD ? head.instr : NOP_INSTR;
   assign PCD      = ValidD ? head.pc : 32'h0;
   assign PCPlus4D = ValidD ? head.pc + 32'd4 : 32'h0;

   a_rsp_credit: assert property (
      @(posedge clk) disable iff (!reset)
      ImemRspValid |-> (inflight_q != '0)
   );

endmodule
